// File: rtl/if_fetch_if.sv
// Fetch-stage bus: PC register handshake, memory controller port and IF/ID delivery.
interface if_fetch_if;
    logic        pc_enable_i;
    logic [31:0] pc_i;
    logic        pc_jump_enable_i;
    logic        inst_ready_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_done_i;
    logic [31:0] mem_data_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    modport master (
        input  pc_enable_i, pc_i, pc_jump_enable_i, mem_done_i, mem_data_i,
        output inst_ready_o, mem_req_o, mem_addr_o, if_valid_o, if_pc_o, if_inst_o
    );

    modport slave (
        output pc_enable_i, pc_i, pc_jump_enable_i, mem_done_i, mem_data_i,
        input  inst_ready_o, mem_req_o, mem_addr_o, if_valid_o, if_pc_o, if_inst_o
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: direct-mapped word I-cache, miss fill over a req/done
// memory port, and jump redirect handling including jumps landing on a delivery edge.
module if_fetch #(
    parameter int unsigned ICACHE_IDX_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        stall_i,
    if_fetch_if.master  bus
);
    localparam int unsigned LINES = 1 << ICACHE_IDX_W;
    localparam int unsigned TAG_W = 32 - ICACHE_IDX_W - 2;

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD, GAP} state_t;

    state_t                  state;
    logic [LINES-1:0]        valid;
    logic [TAG_W-1:0]        tag_mem  [LINES];
    logic [31:0]             data_mem [LINES];
    logic                    redirect_pending;
    logic [31:0]             redirect_pc;

    logic [31:0]             fetch_addr;
    logic [ICACHE_IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0]        lk_tag;
    logic                    hit;
    logic [ICACHE_IDX_W-1:0] fill_idx;
    logic                    fill_en;

    always_comb begin
        fetch_addr = redirect_pending ? redirect_pc : bus.pc_i;
        lk_idx     = fetch_addr[ICACHE_IDX_W+1:2];
        lk_tag     = fetch_addr[31:ICACHE_IDX_W+2];
        hit        = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
        fill_idx   = bus.mem_addr_o[ICACHE_IDX_W+1:2];
        // A discarded request still fills: its address was legitimate.
        fill_en    = rdy && bus.mem_done_i && ((state == WAIT) || (state == DISCARD));
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= bus.mem_addr_o[31:ICACHE_IDX_W+2];
            data_mem[fill_idx] <= bus.mem_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            valid            <= '0;
            redirect_pending <= 1'b0;
            redirect_pc      <= '0;
            bus.inst_ready_o <= 1'b0;
            bus.mem_req_o    <= 1'b0;
            bus.mem_addr_o   <= '0;
            bus.if_valid_o   <= 1'b0;
            bus.if_pc_o      <= '0;
            bus.if_inst_o    <= '0;
        end else if (rdy) begin
            bus.inst_ready_o <= 1'b0;
            bus.if_valid_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.pc_enable_i && !stall_i) begin
                        if (hit) begin
                            bus.if_valid_o   <= 1'b1;
                            bus.if_pc_o      <= fetch_addr;
                            bus.if_inst_o    <= data_mem[lk_idx];
                            // Quiet delivery: the PC register already moved past the target.
                            bus.inst_ready_o <= !redirect_pending;
                            redirect_pending <= 1'b0;
                            state            <= GAP;
                        end else begin
                            bus.mem_req_o  <= 1'b1;
                            bus.mem_addr_o <= fetch_addr;
                            state          <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.mem_done_i) begin
                        valid[fill_idx] <= 1'b1;
                        bus.mem_req_o   <= 1'b0;
                        state           <= IDLE;
                    end else if (bus.pc_jump_enable_i) begin
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (bus.mem_done_i) begin
                        valid[fill_idx] <= 1'b1;
                        bus.mem_req_o   <= 1'b0;
                        state           <= IDLE;
                    end
                end
                GAP: begin
                    if (bus.pc_jump_enable_i) begin
                        redirect_pc      <= bus.pc_i;
                        redirect_pending <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch; the bench plays both PC register and memory controller.
module tb_if_fetch;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    logic stall_i = 1'b0;
    int   checks = 0;
    int   failures = 0;

    if_fetch_if ifc ();

    if_fetch #(.ICACHE_IDX_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .rdy     (rdy),
        .stall_i (stall_i),
        .bus     (ifc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_pulses(input string tag);
        chk({tag, "_valid"}, 32'(ifc.if_valid_o), 32'd0);
        chk({tag, "_ready"}, 32'(ifc.inst_ready_o), 32'd0);
    endtask

    task automatic chk_req(input string tag, input logic [31:0] addr);
        chk({tag, "_req"}, 32'(ifc.mem_req_o), 32'd1);
        chk({tag, "_addr"}, ifc.mem_addr_o, addr);
    endtask

    task automatic chk_deliver(input string tag, input logic [31:0] pc, input logic ready);
        chk({tag, "_valid"}, 32'(ifc.if_valid_o), 32'd1);
        chk({tag, "_ready"}, 32'(ifc.inst_ready_o), 32'(ready));
        chk({tag, "_pc"}, ifc.if_pc_o, pc);
        chk({tag, "_inst"}, ifc.if_inst_o, inst_of(pc));
    endtask

    // Pulse mem_done_i with the word for addr for one edge, then check the request dropped.
    task automatic mem_return(input string tag, input logic [31:0] addr);
        ifc.mem_done_i = 1'b1;
        ifc.mem_data_i = inst_of(addr);
        tick();
        ifc.mem_done_i = 1'b0;
        ifc.mem_data_i = '0;
        chk({tag, "_reqdrop"}, 32'(ifc.mem_req_o), 32'd0);
        chk_idle_pulses({tag, "_fill"});
    endtask

    initial begin
        ifc.pc_enable_i      = 1'b1;
        ifc.pc_i             = 32'h0;
        ifc.pc_jump_enable_i = 1'b0;
        ifc.mem_done_i       = 1'b0;
        ifc.mem_data_i       = '0;

        // Reset state
        tick();
        tick();
        chk("rst_ready", 32'(ifc.inst_ready_o), 32'd0);
        chk("rst_req", 32'(ifc.mem_req_o), 32'd0);
        chk("rst_valid", 32'(ifc.if_valid_o), 32'd0);
        chk("rst_addr", ifc.mem_addr_o, 32'd0);
        chk("rst_pc", ifc.if_pc_o, 32'd0);
        chk("rst_inst", ifc.if_inst_o, 32'd0);

        // Cold start, memory latency 3
        rst = 1'b1;
        tick();
        chk_req("cold", 32'h0);
        tick();
        tick();
        chk_req("cold_wait", 32'h0);
        chk_idle_pulses("cold_wait");
        mem_return("cold", 32'h0);
        tick();
        chk_deliver("cold_dlv", 32'h0, 1'b1);
        tick();
        chk_idle_pulses("cold_gap");

        // Hit path: jump back to 0x0, then a second hit exactly 2 cycles later
        ifc.pc_i = 32'h0;
        ifc.pc_jump_enable_i = 1'b1;
        tick();
        ifc.pc_jump_enable_i = 1'b0;
        chk_deliver("hit1", 32'h0, 1'b1);
        chk("hit1_noreq", 32'(ifc.mem_req_o), 32'd0);
        tick();
        chk_idle_pulses("hit_gap");
        tick();
        chk_deliver("hit2", 32'h0, 1'b1);
        tick();

        // Jump during miss: 0x10 discarded but cached, then 0x80 (aliases index 0)
        ifc.pc_i = 32'h10;
        tick();
        chk_req("jm_miss", 32'h10);
        tick();
        ifc.pc_jump_enable_i = 1'b1;
        ifc.pc_i = 32'h80;
        tick();
        ifc.pc_jump_enable_i = 1'b0;
        chk_req("jm_discard", 32'h10);
        mem_return("jm_discard", 32'h10);
        tick();
        chk_req("jm_target", 32'h80);
        chk_idle_pulses("jm_target");
        mem_return("jm_target", 32'h80);
        tick();
        chk_deliver("jm_dlv", 32'h80, 1'b1);
        tick();
        ifc.pc_i = 32'h10;
        tick();
        chk_deliver("jm_cached10", 32'h10, 1'b1);
        chk("jm_cached10_noreq", 32'(ifc.mem_req_o), 32'd0);
        tick();

        // Conflict: 0x80 replaced index 0, so 0x0 misses, then 0x80 misses again
        ifc.pc_i = 32'h0;
        tick();
        chk_req("alias0", 32'h0);
        mem_return("alias0", 32'h0);
        tick();
        chk_deliver("alias0_dlv", 32'h0, 1'b1);
        tick();
        ifc.pc_i = 32'h80;
        tick();
        chk_req("alias80", 32'h80);
        mem_return("alias80", 32'h80);
        tick();
        chk_deliver("alias80_dlv", 32'h80, 1'b1);
        tick();

        // Jump on the delivery edge: quiet delivery of 0x200, then 0x204 normally
        ifc.pc_i = 32'h10;
        tick();
        chk_deliver("jd_pre", 32'h10, 1'b1);
        ifc.pc_jump_enable_i = 1'b1;
        ifc.pc_i = 32'h200;
        tick();
        ifc.pc_jump_enable_i = 1'b0;
        ifc.pc_i = 32'h204;
        chk_idle_pulses("jd_gap");
        tick();
        chk_req("jd_redirect", 32'h200);
        mem_return("jd_redirect", 32'h200);
        tick();
        chk_deliver("jd_quiet", 32'h200, 1'b0);
        tick();
        tick();
        chk_req("jd_next", 32'h204);
        mem_return("jd_next", 32'h204);
        tick();
        chk_deliver("jd_next_dlv", 32'h204, 1'b1);
        tick();

        // Stall held 5 cycles in IDLE on a cached PC
        ifc.pc_i = 32'h10;
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_idle_pulses("stall");
            chk("stall_noreq", 32'(ifc.mem_req_o), 32'd0);
        end
        stall_i = 1'b0;
        tick();
        chk_deliver("stall_resume", 32'h10, 1'b1);
        tick();

        // rdy=0 during WAIT with mem_done_i: nothing changes
        ifc.pc_i = 32'h300;
        tick();
        chk_req("rdy_miss", 32'h300);
        rdy = 1'b0;
        ifc.mem_done_i = 1'b1;
        ifc.mem_data_i = inst_of(32'h300);
        tick();
        chk_req("rdy_hold1", 32'h300);
        ifc.mem_done_i = 1'b0;
        tick();
        chk_req("rdy_hold2", 32'h300);
        chk_idle_pulses("rdy_hold2");
        rdy = 1'b1;
        mem_return("rdy_fill", 32'h300);
        tick();
        chk_deliver("rdy_dlv", 32'h300, 1'b1);
        tick();

        // Async reset in WAIT: request drops at once, cache invalidated
        ifc.pc_i = 32'h400;
        tick();
        chk_req("ar_miss", 32'h400);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_reqdrop", 32'(ifc.mem_req_o), 32'd0);
        chk("ar_addr", ifc.mem_addr_o, 32'd0);
        tick();
        rst = 1'b1;
        ifc.pc_i = 32'h10;
        tick();
        chk_req("ar_refetch", 32'h10);
        mem_return("ar_refetch", 32'h10);
        tick();
        chk_deliver("ar_dlv", 32'h10, 1'b1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
